// File: rtl/memory_part_param.sv
// memory_part_param: dual-port byte-lane RAM with optional output register,
// out-of-range flagging and a word-per-cycle hardware zero-fill engine.
module memory_part_param #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [31:0]             a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic                    a_ready,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic [DATA_WIDTH/8-1:0] b_we,
  input  logic [31:0]             b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_ready,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            req;
  logic [1:0]            ready;
  logic [1:0]            acc;
  logic [1:0]            rd_acc;
  logic [1:0]            wr_ok;
  logic [1:0]            oor;
  logic [NB-1:0]         we    [2];
  logic [31:0]           addr  [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [ADDR_WIDTH-1:0] idx   [2];

  assign req      = {b_req, a_req};
  assign we[0]    = a_we;
  assign we[1]    = b_we;
  assign addr[0]  = a_addr;
  assign addr[1]  = b_addr;
  assign wdata[0] = a_wdata;
  assign wdata[1] = b_wdata;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign ready[p]  = (state == IDLE) & ~rst;
    assign acc[p]    = req[p] & ready[p];
    assign oor[p]    = |(addr[p] >> ADDR_WIDTH);
    assign rd_acc[p] = acc[p] & ~(|we[p]);
    assign wr_ok[p]  = acc[p] & (|we[p]) & ~oor[p];
    assign idx[p]    = addr[p][ADDR_WIDTH-1:0];
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // Fill engine
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (clr_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == '1) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A reset landing mid-fill must not zero the word under the counter.
  assign clr_we   = (state == CLEAR) & ~rst;
  assign clr_busy = (state == CLEAR) & ~rst;
  assign clr_done = (state == DONE) & ~rst;

  // Port A is applied last so it owns any lane both ports enable.
  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt] <= '0;
    for (int p = 1; p >= 0; p--) begin
      for (int l = 0; l < NB; l++) begin
        if (wr_ok[p] && we[p][l]) begin
          mem[idx[p]][8*l +: 8] <= wdata[p][8*l +: 8];
        end
      end
    end
  end

  logic [1:0]            v1;
  logic [1:0]            e1;
  logic [DATA_WIDTH-1:0] d1 [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= '0;
      e1    <= '0;
      d1[0] <= '0;
      d1[1] <= '0;
    end else begin
      v1 <= rd_acc;
      e1 <= acc & oor;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) d1[p] <= oor[p] ? '0 : mem[idx[p]];
      end
    end
  end

  logic [1:0]            v_o;
  logic [1:0]            e_o;
  logic [DATA_WIDTH-1:0] d_o [2];

  if (OUT_REG != 0) begin : g_oreg
    logic [1:0]            v2;
    logic [1:0]            e2;
    logic [DATA_WIDTH-1:0] d2 [2];

    always_ff @(posedge clk) begin
      if (rst) begin
        v2    <= '0;
        e2    <= '0;
        d2[0] <= '0;
        d2[1] <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        for (int p = 0; p < 2; p++) begin
          if (v1[p]) d2[p] <= d1[p];
        end
      end
    end

    assign v_o    = v2;
    assign e_o    = e2;
    assign d_o[0] = d2[0];
    assign d_o[1] = d2[1];
  end else begin : g_noreg
    assign v_o    = v1;
    assign e_o    = e1;
    assign d_o[0] = d1[0];
    assign d_o[1] = d1[1];
  end

  assign a_rvalid = v_o[0] & ~rst;
  assign b_rvalid = v_o[1] & ~rst;
  assign a_err    = e_o[0] & ~rst;
  assign b_err    = e_o[1] & ~rst;
  assign a_rdata  = rst ? '0 : d_o[0];
  assign b_rdata  = rst ? '0 : d_o[1];

endmodule

// File: tb/tb_memory_part_param.sv
// tb_memory_part_param: directed and random traffic on two instances
// (OUT_REG 0 and 1) checked against an array-based memory model.
module tb_memory_part_param;

  localparam int MAXC = 2048;

  logic        clk;
  logic        rst;
  logic        clr_start;
  logic [1:0]  req;
  logic [3:0]  we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic [1:0]  rdy  [2];
  logic [1:0]  rv   [2];
  logic [1:0]  er   [2];
  logic [31:0] rd   [2][2];
  logic        busy [2];
  logic        done [2];

  int n_chk;
  int n_fail;
  int k;
  int clr_pos;

  logic [31:0] mdl  [16];
  logic [31:0] held [2][2];
  bit          ev   [2][2][MAXC];
  bit          ee   [2][2][MAXC];
  logic [31:0] ed   [2][2][MAXC];

  memory_part_param #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ready(rdy[0][0]), .a_rvalid(rv[0][0]), .a_rdata(rd[0][0]),
    .a_err(er[0][0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ready(rdy[0][1]), .b_rvalid(rv[0][1]), .b_rdata(rd[0][1]),
    .b_err(er[0][1]),
    .clr_start(clr_start), .clr_busy(busy[0]), .clr_done(done[0])
  );

  memory_part_param #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ready(rdy[1][0]), .a_rvalid(rv[1][0]), .a_rdata(rd[1][0]),
    .a_err(er[1][0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ready(rdy[1][1]), .b_rvalid(rv[1][1]), .b_rdata(rd[1][1]),
    .b_err(er[1][1]),
    .clr_start(clr_start), .clr_busy(busy[1]), .clr_done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int p, input logic [31:0] a,
                    input logic [3:0] w, input logic [31:0] dat);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = dat;
  endtask

  task automatic rdq(input int p, input logic [31:0] a);
    req[p]  = 1'b1;
    we[p]   = 4'b0000;
    addr[p] = a;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, clock.
  task automatic cyc();
    logic [31:0] rdv [2];
    logic [3:0]  ix  [2];
    bit          bad [2];
    bit          e_rdy;
    bit          e_busy;
    bit          e_done;
    int          lat;
    @(negedge clk);
    e_rdy  = !rst && (clr_pos < 0);
    e_busy = !rst && (clr_pos >= 0) && (clr_pos < 16);
    e_done = !rst && (clr_pos == 16);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d clr_busy c%0d", d, k), 32'(busy[d]), 32'(e_busy));
      chk($sformatf("u%0d clr_done c%0d", d, k), 32'(done[d]), 32'(e_done));
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          held[d][p] = '0;
          for (int j = 0; j < 3; j++) begin
            ev[d][p][k+j] = 1'b0;
            ee[d][p][k+j] = 1'b0;
          end
        end else if (ev[d][p][k]) begin
          held[d][p] = ed[d][p][k];
        end
        chk($sformatf("u%0d p%0d ready c%0d", d, p, k),
            32'(rdy[d][p]), 32'(e_rdy));
        chk($sformatf("u%0d p%0d rvalid c%0d", d, p, k),
            32'(rv[d][p]), 32'(!rst && ev[d][p][k]));
        chk($sformatf("u%0d p%0d err c%0d", d, p, k),
            32'(er[d][p]), 32'(!rst && ee[d][p][k]));
        chk($sformatf("u%0d p%0d rdata c%0d", d, p, k),
            rd[d][p], held[d][p]);
      end
    end
    if (rst) begin
      clr_pos = -1;
    end else if (clr_pos < 0) begin
      for (int p = 0; p < 2; p++) begin
        ix[p]  = addr[p][3:0];
        bad[p] = addr[p] > 32'd15;
        rdv[p] = bad[p] ? 32'd0 : mdl[ix[p]];
      end
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          for (int d = 0; d < 2; d++) begin
            lat = d + 1;
            if (we[p] == 4'b0000) begin
              ev[d][p][k+lat] = 1'b1;
              ed[d][p][k+lat] = rdv[p];
            end
            ee[d][p][k+lat] = bad[p];
          end
        end
      end
      for (int l = 0; l < 4; l++) begin
        if (req[0] && !bad[0] && we[0][l])
          mdl[ix[0]][8*l +: 8] = wdata[0][8*l +: 8];
        if (req[1] && !bad[1] && we[1][l] &&
            !(req[0] && !bad[0] && we[0][l] && ix[0] == ix[1]))
          mdl[ix[1]][8*l +: 8] = wdata[1][8*l +: 8];
      end
      if (clr_start) clr_pos = 0;
    end else if (clr_pos < 16) begin
      mdl[clr_pos] = '0;
      clr_pos++;
    end else begin
      clr_pos = -1;
    end
    @(posedge clk);
    #1;
    k++;
    req       = '0;
    clr_start = 1'b0;
  endtask

  logic [31:0] tmp;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    k         = 0;
    clr_pos   = -1;
    rst       = 1'b1;
    clr_start = 1'b0;
    req       = '0;
    for (int p = 0; p < 2; p++) begin
      we[p]    = '0;
      addr[p]  = '0;
      wdata[p] = '0;
      held[0][p] = '0;
      held[1][p] = '0;
    end
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    repeat (3) cyc();
    rst = 1'b0;

    // Initial zero-fill, with a second start and a write attempt mid-fill
    clr_start = 1'b1;
    cyc();
    for (int i = 0; i < 18; i++) begin
      if (i == 3) clr_start = 1'b1;
      if (i == 8) wr(0, 32'd0, 4'hF, 32'hFFFF_FFFF);
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      rdq(0, 32'(i));
      rdq(1, 32'(15 - i));
      cyc();
    end
    repeat (3) cyc();

    // Byte-lane merge
    wr(0, 32'd3, 4'b1111, 32'hDEAD_BEEF);
    cyc();
    wr(0, 32'd3, 4'b0010, 32'h0000_5500);
    cyc();
    rdq(1, 32'd3);
    cyc();
    cyc();
    cyc();
    chk("merge u0", rd[0][1], 32'hDEAD_55EF);
    chk("merge u1", rd[1][1], 32'hDEAD_55EF);

    // Same-cycle same-address writes
    wr(0, 32'd5, 4'b1111, 32'h2222_2222);
    cyc();
    wr(0, 32'd5, 4'b0011, 32'h1111_1111);
    wr(1, 32'd5, 4'b0110, 32'h2222_2222);
    cyc();
    rdq(0, 32'd5);
    cyc();
    cyc();
    cyc();
    chk("collide u0", rd[0][0], 32'h2222_1111);
    chk("collide u1", rd[1][0], 32'h2222_1111);

    // Read-first against the other port
    wr(0, 32'd7, 4'hF, 32'hA5A5_A5A5);
    cyc();
    rdq(0, 32'd7);
    wr(1, 32'd7, 4'hF, 32'd0);
    cyc();
    cyc();
    cyc();
    chk("rdfirst u0", rd[0][0], 32'hA5A5_A5A5);
    chk("rdfirst u1", rd[1][0], 32'hA5A5_A5A5);
    rdq(0, 32'd7);
    cyc();
    cyc();
    cyc();
    chk("reread u0", rd[0][0], 32'd0);
    chk("reread u1", rd[1][0], 32'd0);

    // Out-of-range read and write
    rdq(0, 32'd3);
    cyc();
    rdq(0, 32'h10);
    cyc();
    cyc();
    cyc();
    chk("oor rd u0", rd[0][0], 32'd0);
    chk("oor rd u1", rd[1][0], 32'd0);
    wr(0, 32'd0, 4'hF, 32'h1234_5678);
    cyc();
    wr(0, 32'h10, 4'hF, 32'hFFFF_FFFF);
    cyc();
    rdq(0, 32'd0);
    cyc();
    cyc();
    cyc();
    chk("oor wr u0", rd[0][0], 32'h1234_5678);
    chk("oor wr u1", rd[1][0], 32'h1234_5678);

    // Requests accepted with clr_start complete before the fill
    wr(0, 32'd9, 4'hF, 32'h0BAD_F00D);
    cyc();
    clr_start = 1'b1;
    wr(0, 32'd9, 4'hF, 32'h1357_9BDF);
    rdq(1, 32'd9);
    cyc();
    repeat (18) cyc();
    chk("clr_start rd u0", rd[0][1], 32'h0BAD_F00D);
    chk("clr_start rd u1", rd[1][1], 32'h0BAD_F00D);

    // Reset mid-fill
    for (int i = 0; i < 8; i++) begin
      wr(0, 32'(2*i), 4'hF, $urandom);
      wr(1, 32'(2*i+1), 4'hF, $urandom);
      cyc();
    end
    tmp = mdl[15];
    clr_start = 1'b1;
    cyc();
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      rdq(0, 32'(i));
      cyc();
    end
    repeat (2) cyc();
    chk("abort keep u0", rd[0][0], tmp);
    chk("abort keep u1", rd[1][0], tmp);

    // Random traffic
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        req[p]   = 1'($urandom_range(0, 1));
        we[p]    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
        addr[p]  = ($urandom_range(0, 7) == 0) ? $urandom
                 : 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) addr[p] = 32'($urandom_range(0, 1));
        wdata[p] = $urandom;
      end
      clr_start = ($urandom_range(0, 79) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
